// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller:
// stage indices, exception kinds and the fixed redirect vectors.
package pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    EXC_GENERAL = 2'd0,
    EXC_INTVEC  = 2'd1,
    EXC_ERET    = 2'd2,
    EXC_RSVD    = 2'd3
  } exc_kind_e;

  localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;
  localparam logic [31:0] INT_VEC_DEF = 32'hBFC00200;

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Compares one ID source register against every stage destination.
// Register 0 never matches, since it is hardwired to zero.
module hazard_match #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         src_en,
  input  logic [NUM_STAGES*REG_AW-1:0] stg_wd,
  output logic [NUM_STAGES-1:0]        match
);

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      match[k] = src_en && (src != '0) && (stg_wd[k*REG_AW +: REG_AW] == src);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for an in-order pipeline, with a
// saturating stall-cycle counter and a sticky stall watchdog.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          NUM_STAGES = 5,
  parameter int          REG_AW     = 5,
  parameter int          LOAD_LAT   = 1,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter logic [31:0] INT_VEC    = INT_VEC_DEF,
  parameter int          WDOG_CYC   = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         inst_stall_i,
  input  logic                         data_stall_i,
  input  logic                         md_busy_i,
  input  logic [REG_AW-1:0]            id_rs_i,
  input  logic [REG_AW-1:0]            id_rt_i,
  input  logic                         id_rs_en_i,
  input  logic                         id_rt_en_i,
  input  logic                         id_is_branch_i,
  input  logic [NUM_STAGES-1:0]        stg_wreg_i,
  input  logic [NUM_STAGES-1:0]        stg_load_i,
  input  logic [NUM_STAGES*REG_AW-1:0] stg_wd_i,
  input  logic                         exc_valid_i,
  input  logic [1:0]                   exc_kind_i,
  input  logic [31:0]                  cp0_epc_i,
  input  logic                         fetch_ready_i,
  output logic [NUM_STAGES-1:0]        stall_o,
  output logic [NUM_STAGES-1:0]        flush_o,
  output logic                         redirect_valid_o,
  output logic [31:0]                  new_pc_o,
  output logic [31:0]                  stall_cnt_o,
  output logic                         watchdog_o
);

  localparam int LD_LAST = (1 + LOAD_LAT > NUM_STAGES - 1) ? NUM_STAGES - 1 : 1 + LOAD_LAT;
  localparam int CW      = $clog2(WDOG_CYC + 1);
  localparam logic [CW-1:0] WDOG_LIM    = CW'(WDOG_CYC);
  localparam logic [CW-1:0] WDOG_LIM_M1 = CW'(WDOG_CYC - 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]            state;
  logic [NUM_STAGES-1:0] rs_match, rt_match, any_match, load_window, hold;
  logic                  global_stall, load_use, br_haz, id_req, any_stall;
  logic [31:0]           exc_target;
  logic [CW-1:0]         consec;
  logic                  unused_wreg;

  hazard_match #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW)) u_rs_match (
    .src(id_rs_i), .src_en(id_rs_en_i), .stg_wd(stg_wd_i), .match(rs_match)
  );

  hazard_match #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW)) u_rt_match (
    .src(id_rt_i), .src_en(id_rt_en_i), .stg_wd(stg_wd_i), .match(rt_match)
  );

  // Stages from EX onward whose load data is still not forwardable to ID.
  always_comb begin
    load_window = '0;
    for (int k = STG_EX; k <= LD_LAST; k++) load_window[k] = 1'b1;
  end

  assign any_match    = rs_match | rt_match;
  assign global_stall = inst_stall_i | data_stall_i | md_busy_i;
  assign load_use     = |(any_match & stg_load_i & load_window);
  assign br_haz       = id_is_branch_i & any_match[STG_EX] & stg_wreg_i[STG_EX];
  assign id_req       = load_use | br_haz;
  assign unused_wreg  = ^stg_wreg_i;

  // An ID hazard holds ID and every stage in front of it.
  always_comb begin
    hold = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      hold[k] = global_stall | (id_req & (k <= STG_ID));
    end
    stall_o = hold;
    if (state == ST_REDIRECT) stall_o[STG_IF] = 1'b1;
  end

  // A bubble enters where a held stage meets a moving one.
  always_comb begin
    flush_o = '0;
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      flush_o[k+1] = stall_o[k] & ~stall_o[k+1] & ~global_stall;
    end
    if (state == ST_REDIRECT) flush_o[STG_ID] = 1'b1;
    else if (exc_valid_i)     flush_o = '1;
  end

  always_comb begin
    exc_target = EXC_VEC;
    case (exc_kind_e'(exc_kind_i))
      EXC_INTVEC: exc_target = INT_VEC;
      EXC_ERET:   exc_target = cp0_epc_i;
      default:    exc_target = EXC_VEC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      new_pc_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exc_valid_i) begin
            state    <= ST_REDIRECT;
            new_pc_o <= exc_target;
          end
        end
        default: begin
          if (fetch_ready_i) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign redirect_valid_o = (state == ST_REDIRECT);
  assign any_stall        = |stall_o;

  // consec saturates at the limit so it can never wrap back under it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      consec      <= '0;
      watchdog_o  <= 1'b0;
    end else begin
      if (any_stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (!any_stall)               consec <= '0;
      else if (consec != WDOG_LIM)  consec <= consec + 1'b1;
      if (any_stall && (consec == WDOG_LIM_M1)) watchdog_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT 1 and 2) share stimulus
// and are compared every cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int WDOG = 1024;
  localparam logic [31:0] EXC_V = 32'hBFC00380;
  localparam logic [31:0] INT_V = 32'hBFC00200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_stall, data_stall, md_busy;
  logic [4:0]  id_rs, id_rt;
  logic        id_rs_en, id_rt_en, id_is_branch;
  logic [4:0]  stg_wreg, stg_load;
  logic [24:0] stg_wd;
  logic        exc_valid;
  logic [1:0]  exc_kind;
  logic [31:0] epc;
  logic        fetch_ready;

  logic [4:0]  stall_w[2];
  logic [4:0]  flush_w[2];
  logic        rv_w[2];
  logic [31:0] pc_w[2];
  logic [31:0] cnt_w[2];
  logic        wd_w[2];

  int tests = 0;
  int fails = 0;

  bit          m_redir[2];
  logic [31:0] m_pc[2];
  longint      m_cnt[2];
  int          m_consec[2];
  bit          m_wd[2];
  int          lat[2] = '{1, 2};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_LAT(1), .WDOG_CYC(WDOG)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .inst_stall_i(inst_stall), .data_stall_i(data_stall),
    .md_busy_i(md_busy), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_en_i(id_rs_en),
    .id_rt_en_i(id_rt_en), .id_is_branch_i(id_is_branch), .stg_wreg_i(stg_wreg),
    .stg_load_i(stg_load), .stg_wd_i(stg_wd), .exc_valid_i(exc_valid),
    .exc_kind_i(exc_kind), .cp0_epc_i(epc), .fetch_ready_i(fetch_ready),
    .stall_o(stall_w[0]), .flush_o(flush_w[0]), .redirect_valid_o(rv_w[0]),
    .new_pc_o(pc_w[0]), .stall_cnt_o(cnt_w[0]), .watchdog_o(wd_w[0])
  );

  pipe_hazard_ctrl #(.LOAD_LAT(2), .WDOG_CYC(WDOG)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .inst_stall_i(inst_stall), .data_stall_i(data_stall),
    .md_busy_i(md_busy), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_en_i(id_rs_en),
    .id_rt_en_i(id_rt_en), .id_is_branch_i(id_is_branch), .stg_wreg_i(stg_wreg),
    .stg_load_i(stg_load), .stg_wd_i(stg_wd), .exc_valid_i(exc_valid),
    .exc_kind_i(exc_kind), .cp0_epc_i(epc), .fetch_ready_i(fetch_ready),
    .stall_o(stall_w[1]), .flush_o(flush_w[1]), .redirect_valid_o(rv_w[1]),
    .new_pc_o(pc_w[1]), .stall_cnt_o(cnt_w[1]), .watchdog_o(wd_w[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit id_reads(int k);
    logic [4:0] d;
    d = stg_wd[k*5 +: 5];
    return (d != 5'd0) && ((id_rs_en && id_rs == d) || (id_rt_en && id_rt == d));
  endfunction

  function automatic logic [4:0] model_stall(int ll, bit redir);
    bit req;
    logic [4:0] s;
    req = 1'b0;
    for (int k = 2; k <= 1 + ll && k < 5; k++) if (stg_load[k] && id_reads(k)) req = 1'b1;
    if (id_is_branch && stg_wreg[2] && id_reads(2)) req = 1'b1;
    if (inst_stall || data_stall || md_busy) s = 5'b11111;
    else if (req)                            s = 5'b00011;
    else                                     s = 5'b00000;
    if (redir) s[0] = 1'b1;
    return s;
  endfunction

  function automatic logic [4:0] model_flush(logic [4:0] s, bit redir);
    logic [4:0] f;
    if (!redir && exc_valid) return 5'b11111;
    f = 5'b00000;
    if (!(inst_stall || data_stall || md_busy))
      for (int k = 0; k < 4; k++) if (s[k] && !s[k+1]) f[k+1] = 1'b1;
    if (redir) f[1] = 1'b1;
    return f;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_redir[d] = 0; m_pc[d] = 32'h0; m_cnt[d] = 0; m_consec[d] = 0; m_wd[d] = 0;
    end
  endtask

  task automatic clearInputs();
    inst_stall = 0; data_stall = 0; md_busy = 0;
    id_rs = 0; id_rt = 0; id_rs_en = 0; id_rt_en = 0; id_is_branch = 0;
    stg_wreg = 0; stg_load = 0; stg_wd = 0;
    exc_valid = 0; exc_kind = 0; epc = 0; fetch_ready = 0;
  endtask

  // Check every output of both instances, clock once, then advance the model.
  task automatic applyStimulus(input string tag);
    logic [4:0] es[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      es[d] = model_stall(lat[d], m_redir[d]);
      checkOutput($sformatf("%s.d%0d.stall", tag, d + 1), 32'(stall_w[d]), 32'(es[d]));
      checkOutput($sformatf("%s.d%0d.flush", tag, d + 1), 32'(flush_w[d]),
                  32'(model_flush(es[d], m_redir[d])));
      checkOutput($sformatf("%s.d%0d.rv", tag, d + 1), 32'(rv_w[d]), 32'(m_redir[d]));
      checkOutput($sformatf("%s.d%0d.pc", tag, d + 1), pc_w[d], m_pc[d]);
      checkOutput($sformatf("%s.d%0d.cnt", tag, d + 1), cnt_w[d], 32'(m_cnt[d]));
      checkOutput($sformatf("%s.d%0d.wd", tag, d + 1), 32'(wd_w[d]), 32'(m_wd[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_redir[d]) begin
        if (fetch_ready) m_redir[d] = 0;
      end else if (exc_valid) begin
        m_redir[d] = 1;
        m_pc[d] = (exc_kind == 2'd2) ? epc : (exc_kind == 2'd1) ? INT_V : EXC_V;
      end
      if (es[d] != 5'b0) begin
        if (m_cnt[d] < 64'hFFFF_FFFF) m_cnt[d]++;
        if (m_consec[d] < WDOG) m_consec[d]++;
        if (m_consec[d] == WDOG) m_wd[d] = 1;
      end else begin
        m_consec[d] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clearInputs();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset.stall", 32'(stall_w[0]), 32'h0);
    checkOutput("reset.flush", 32'(flush_w[0]), 32'h0);
    checkOutput("reset.rv", 32'(rv_w[0]), 32'h0);
    checkOutput("reset.pc", pc_w[0], 32'h0);
    checkOutput("reset.cnt", cnt_w[1], 32'h0);
    checkOutput("reset.wd", 32'(wd_w[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use on EX with LOAD_LAT=1
    id_rs = 5; id_rs_en = 1; stg_load = 5'b00100; stg_wreg = 5'b00100; stg_wd = 25'(5) << 10;
    #1;
    checkOutput("t1.stall", 32'(stall_w[0]), 32'h03);
    checkOutput("t1.flush", 32'(flush_w[0]), 32'h04);
    applyStimulus("t1");
    // Load moved to MEM: only the LOAD_LAT=2 instance still stalls
    stg_load = 5'b01000; stg_wreg = 5'b01000; stg_wd = 25'(5) << 15;
    #1;
    checkOutput("t2.d1.stall", 32'(stall_w[0]), 32'h00);
    checkOutput("t2.d2.stall", 32'(stall_w[1]), 32'h03);
    applyStimulus("t2");
    stg_load = 5'b10000; stg_wreg = 5'b10000; stg_wd = 25'(5) << 20;
    #1;
    checkOutput("t2.wb.stall", 32'(stall_w[1]), 32'h00);
    applyStimulus("t2b");

    // Global stall overlapping load-use, then release
    stg_load = 5'b00100; stg_wreg = 5'b00100; stg_wd = 25'(5) << 10; data_stall = 1;
    #1;
    checkOutput("t3.stall", 32'(stall_w[0]), 32'h1F);
    checkOutput("t3.flush", 32'(flush_w[0]), 32'h00);
    applyStimulus("t3");
    data_stall = 0;
    #1;
    checkOutput("t3.bubble", 32'(flush_w[0]), 32'h04);
    applyStimulus("t3b");

    // Branch operand hazard on a non-load EX writer
    stg_load = 0; id_is_branch = 1; id_rs = 0; id_rs_en = 0; id_rt = 5; id_rt_en = 1;
    applyStimulus("brhaz");

    // Register zero never matches
    clearInputs();
    id_rs = 0; id_rs_en = 1; id_rt = 0; id_rt_en = 1; id_is_branch = 1;
    stg_load = 5'b01100; stg_wreg = 5'b01100; stg_wd = 25'h0;
    #1;
    checkOutput("t5.stall", 32'(stall_w[1]), 32'h00);
    applyStimulus("t5");

    // ERET redirect with fetch not ready for three cycles
    clearInputs();
    exc_valid = 1; exc_kind = 2; epc = 32'h8000_1000;
    #1;
    checkOutput("t4.flush", 32'(flush_w[0]), 32'h1F);
    checkOutput("t4.rv0", 32'(rv_w[0]), 32'h0);
    applyStimulus("t4a");
    exc_kind = 0;
    for (int i = 0; i < 4; i++) begin
      fetch_ready = (i == 3);
      #1;
      checkOutput($sformatf("t4.rv%0d", i + 1), 32'(rv_w[0]), 32'h1);
      checkOutput($sformatf("t4.pc%0d", i + 1), pc_w[0], 32'h8000_1000);
      applyStimulus("t4r");
    end
    exc_valid = 0; fetch_ready = 0;
    #1;
    checkOutput("t4.rvend", 32'(rv_w[0]), 32'h0);
    applyStimulus("t4e");

    // Asynchronous reset mid-redirect
    exc_valid = 1; exc_kind = 1;
    applyStimulus("ar");
    exc_valid = 0;
    rst = 1'b1;
    #1;
    checkOutput("areset.rv", 32'(rv_w[0]), 32'h0);
    checkOutput("areset.pc", pc_w[0], 32'h0);
    doReset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      inst_stall   = ($urandom_range(0, 9) == 0);
      data_stall   = ($urandom_range(0, 9) == 0);
      md_busy      = ($urandom_range(0, 9) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rs_en     = 1'($urandom);
      id_rt_en     = 1'($urandom);
      id_is_branch = 1'($urandom);
      stg_wreg     = 5'($urandom);
      stg_load     = 5'($urandom);
      for (int k = 0; k < 5; k++) stg_wd[k*5 +: 5] = 5'($urandom_range(0, 3));
      exc_valid    = ($urandom_range(0, 7) == 0);
      exc_kind     = 2'($urandom);
      epc          = $urandom;
      fetch_ready  = 1'($urandom);
      applyStimulus("rand");
    end

    // Watchdog: exactly WDOG stalled cycles from reset
    doReset();
    inst_stall = 1;
    for (int i = 0; i < WDOG; i++) applyStimulus("wdog");
    #1;
    checkOutput("t6.wd", 32'(wd_w[0]), 32'h1);
    checkOutput("t6.cnt", cnt_w[0], 32'(WDOG));
    inst_stall = 0;
    for (int i = 0; i < 3; i++) applyStimulus("wdrel");
    checkOutput("t6.sticky", 32'(wd_w[0]), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
